// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment driver for NUM_DIGITS BCD digits.
// Latches a tear-free snapshot of the digit bus, scans one digit per slot onto
// shared active-low segment lines, inserts blank time between digits and
// pulses frame_done once per full scan.
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks leading zero digits
// (digit 0 is never blanked).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bcd_in      packed BCD digits, digit i = bcd_in[4i+3:4i]
//   dp_in       decimal-point request per digit, active-high
//   load        single-cycle strobe capturing bcd_in/dp_in
//   seg         {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   an          anode enables, active-low, an[i] drives digit i
//   frame_done  one-cycle pulse at the end of each full scan
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLANK_CYC   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BCD_W-1:0]        shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [BCD_W-1:0]        disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    pending_q, pending_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    cnt_wrap_c;
  logic                    frame_start_c;
  logic [3:0]              cur_digit_c;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lz_blank_c;
`endif

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Next-state, snapshot handling and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    cur_digit_c  = 4'd0;

    cnt_wrap_c    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_start_c = cnt_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_done_d  = frame_start_c;

    // Slot counter and digit index wrap by compare
    if (cnt_wrap_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_BLANK: if (!cnt_wrap_c && cnt_d == CNT_W'(BLANK_CYC)) state_d = ST_ON;
      ST_ON:    if (cnt_wrap_c) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    // A load at frame start goes straight to the display and leaves the
    // shadow untouched; otherwise the shadow is transferred only at frame start
    if (frame_start_c) begin
      if (load) begin
        disp_bcd_d = bcd_in;
        disp_dp_d  = dp_in;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        disp_bcd_d = shadow_bcd_q;
        disp_dp_d  = shadow_dp_q;
        pending_d  = 1'b0;
      end
    end else if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) cur_digit_c = disp_bcd_q[4*i +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when the current digit and every higher digit are zero
    lz_blank_c = (idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) >= idx_q && disp_bcd_q[4*i +: 4] != 4'd0) lz_blank_c = 1'b0;
    end
`endif

    if (state_q == ST_ON) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IDX_W'(i) == idx_q) begin
          an_d[i] = 1'b0;
          dp_d    = ~disp_dp_q[i];
        end
      end
      seg_d = decode(cur_digit_c);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_blank_c) seg_d = 7'h7F;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYC=1 (16-cycle frames). cyc counts edges since reset release, so
// outputs seen at cyc reflect the scan position cyc-1.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZH = SB;
`else
  localparam logic [6:0] ZH = S0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpin;
    logic            dbl;
    logic [15:0]     pre;
    logic [3:0][6:0] seg_e;
    logic [3:0]      dp_e;
  } vec_t;

  vec_t vecs [5];

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .BLANK_CYC  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                     input logic dp_e, input logic fd_e);
    checks++;
    if ({an, seg, dp, frame_done} !== {an_e, seg_e, dp_e, fd_e}) begin
      errors++;
      $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b fd=%b exp an=%b seg=%b dp=%b fd=%b",
               name, cyc, an, seg, dp, frame_done, an_e, seg_e, dp_e, fd_e);
    end
  endtask

  task automatic load_pulse(input logic [15:0] b, input logic [3:0] d);
    load   = 1'b1;
    bcd_in = b;
    dp_in  = d;
    tick();
    load   = 1'b0;
  endtask

  function automatic logic [3:0] an_for(input int d);
    logic [3:0] a;
    a    = 4'b1111;
    a[d] = 1'b0;
    return a;
  endfunction

  // Check every slot of frame f: blank cycle, one ON cycle, and frame_done
  task automatic check_frame(input int f, input logic [3:0][6:0] se, input logic [3:0] de,
                             input string tag);
    for (int d = 0; d < 4; d++) begin
      wait_until(16*f + 4*d + 1);
      chk($sformatf("%s_d%0d_blank", tag, d), 4'b1111, SB, 1'b1, 1'b0);
      wait_until(16*f + 4*d + 2);
      chk($sformatf("%s_d%0d_on", tag, d), an_for(d), se[d], de[d], 1'b0);
    end
    wait_until(16*f + 16);
    chk($sformatf("%s_frame_done", tag), 4'b0111, se[3], de[3], 1'b1);
  endtask

  initial begin
    logic [3:0][6:0] prev_seg;
    logic [3:0]      prev_dp;
    logic [3:0][6:0] zeros;
    logic [3:0][6:0] s4321;
    int              f;
    int              j;

    // {bcd, dp_in, double-load, first load, expected seg d3..d0, expected dp d3..d0}
    vecs[0] = '{16'h1930, 4'b0100, 1'b0, 16'h0000, {S1, S9, S3, S0}, 4'b1011};
    vecs[1] = '{16'h8642, 4'b1011, 1'b0, 16'h0000, {S8, S6, S4, S2}, 4'b0100};
    vecs[2] = '{16'h00AF, 4'b0000, 1'b0, 16'h0000, {ZH, ZH, SD, SD}, 4'b1111};
    vecs[3] = '{16'h0705, 4'b0010, 1'b0, 16'h0000, {ZH, S7, S0, S5}, 4'b1101};
    vecs[4] = '{16'h2222, 4'b0000, 1'b1, 16'h1111, {S2, S2, S2, S2}, 4'b1111};
    zeros   = {ZH, ZH, ZH, S0};
    s4321   = {S4, S3, S2, S1};

    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;

    // Free-running scan of the reset display for 20 cycles
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (cyc == 0) begin
        chk("reset_state", 4'b1111, SB, 1'b1, 1'b0);
      end else begin
        j = cyc - 1;
        if (j % 4 == 0)
          chk("scan_blank", 4'b1111, SB, 1'b1, 1'b0);
        else
          chk("scan_on", an_for((j / 4) % 4), ((j / 4) % 4 == 0) ? S0 : ZH, 1'b1,
              (j % 16 == 15) ? 1'b1 : 1'b0);
      end
    end

    // Mid-frame loads: old content holds until the next frame start
    prev_seg = zeros;
    prev_dp  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      f = cyc / 16 + 1;
      wait_until(16*f + 5);
      load_pulse(vecs[i].dbl ? vecs[i].pre : vecs[i].bcd, vecs[i].dpin);
      wait_until(16*f + 10);
      chk($sformatf("v%0d_hold", i), 4'b1011, prev_seg[2], prev_dp[2], 1'b0);
      if (vecs[i].dbl) begin
        wait_until(16*f + 11);
        load_pulse(vecs[i].bcd, vecs[i].dpin);
      end
      check_frame(f + 1, vecs[i].seg_e, vecs[i].dp_e, $sformatf("v%0d", i));
      prev_seg = vecs[i].seg_e;
      prev_dp  = vecs[i].dp_e;
    end

    // Load in the exact frame-start cycle bypasses the shadow
    f = cyc / 16 + 1;
    wait_until(16*f - 1);
    load_pulse(16'h4321, 4'b0000);
    check_frame(f, s4321, 4'b1111, "fs_load");
    check_frame(f + 1, s4321, 4'b1111, "fs_after");

    // Reset mid-scan with a load pending and a load coincident with reset
    f = cyc / 16 + 1;
    wait_until(16*f + 3);
    load_pulse(16'h9999, 4'b1111);
    wait_until(16*f + 10);
    rst    = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h5555;
    dp_in  = 4'b1111;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;
    chk("rst_mid_scan", 4'b1111, SB, 1'b1, 1'b0);
    tick();
    chk("rst_first_blank", 4'b1111, SB, 1'b1, 1'b0);
    check_frame(0, zeros, 4'b1111, "rst_f0");
    check_frame(1, zeros, 4'b1111, "rst_f1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
